// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: next-PC select, IF/ID valid, flush.
// Optional misaligned-redirect trap enabled by defining PC_TRAP_EN.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        imem_ready,
  output logic [31:0] pc_next,
  output logic        fetch_valid,
  output logic        flush,
  output logic [31:0] fetch_count,
  output logic        trap
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [31:0] redir_tgt;
  logic        redir_trap;

`ifdef PC_TRAP_EN
  always_comb begin
    redir_trap = (redirect_pc[1:0] != 2'b00);
    redir_tgt  = redir_trap ? TRAP_VEC : redirect_pc;
  end
`else
  // Low address bits are dropped, so a misaligned target is truncated.
  logic unused_cfg;
  assign unused_cfg = ^{TRAP_VEC, redirect_pc[1:0]};

  always_comb begin
    redir_trap = 1'b0;
    redir_tgt  = {redirect_pc[31:2], 2'b00};
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= 32'd0;
    end else if (fetch_valid) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_next     = pc_cur;
    fetch_valid = 1'b0;
    flush       = 1'b0;
    trap        = 1'b0;
    if (rst) begin
      state_d = BOOT;
      pc_next = RESET_PC;
    end else begin
      unique case (state_q)
        BOOT: begin
          state_d = RUN;
        end
        RUN, WAIT: begin
          // Redirect outranks stall and wait: flush kills whatever is held.
          if (redirect) begin
            pc_next = redir_tgt;
            flush   = 1'b1;
            trap    = redir_trap;
            state_d = RUN;
          end else if (stall) begin
            pc_next = pc_cur;
          end else if (!imem_ready) begin
            pc_next = pc_cur;
            state_d = WAIT;
          end else begin
            pc_next     = pc_cur + 32'd4;
            fetch_valid = 1'b1;
            state_d     = RUN;
          end
        end
        default: begin
          state_d = BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed-vector bench for fetch_ctrl with a behavioural PC register.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] pc_cur;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_ready;
  logic [31:0] pc_next;
  logic        fetch_valid;
  logic        flush;
  logic [31:0] fetch_count;
  logic        trap;

  int n_tests;
  int n_fail;

  fetch_ctrl #(
    .RESET_PC(32'h0000_0000),
    .TRAP_VEC(32'h0000_0004)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_cur     (pc_cur),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_ready (imem_ready),
    .pc_next    (pc_next),
    .fetch_valid(fetch_valid),
    .flush      (flush),
    .fetch_count(fetch_count),
    .trap       (trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) pc_cur <= pc_next;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic rd,
                       input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    rst         = r;
    stall       = s;
    redirect    = rd;
    redirect_pc = rpc;
    imem_ready  = rdy;
    #1;
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    pc_cur      = 32'h0;
    rst         = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    imem_ready  = 1'b1;

    drive(1, 0, 0, 0, 1);
    check("rst_pc", pc_next, 32'h0);
    check("rst_fv", {31'd0, fetch_valid}, 32'd0);
    drive(1, 0, 0, 0, 1);
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_trap", {31'd0, trap}, 32'd0);
    drive(1, 0, 0, 0, 1);
    check("rst_cnt", fetch_count, 32'd0);

    drive(0, 0, 0, 0, 1);
    check("boot_fv", {31'd0, fetch_valid}, 32'd0);
    check("boot_pc", pc_next, 32'h0);
    drive(0, 0, 0, 0, 1);
    check("f0_fv", {31'd0, fetch_valid}, 32'd1);
    check("f0_pc", pc_next, 32'h4);
    drive(0, 0, 0, 0, 1);
    check("f1_pc", pc_next, 32'h8);
    drive(0, 0, 0, 0, 1);
    check("f2_pc", pc_next, 32'hC);
    drive(0, 0, 0, 0, 1);
    check("cnt3", fetch_count, 32'd3);
    check("f3_pc", pc_next, 32'h10);

    drive(0, 0, 0, 0, 0);
    check("w1_pc", pc_next, 32'h10);
    check("w1_fv", {31'd0, fetch_valid}, 32'd0);
    drive(0, 0, 0, 0, 0);
    check("w2_pc", pc_next, 32'h10);
    check("w2_fv", {31'd0, fetch_valid}, 32'd0);
    drive(0, 0, 0, 0, 1);
    check("w_end_pc", pc_next, 32'h14);
    check("w_end_fv", {31'd0, fetch_valid}, 32'd1);

    drive(0, 1, 1, 32'h200, 1);
    check("rs_flush", {31'd0, flush}, 32'd1);
    check("rs_pc", pc_next, 32'h200);
    check("rs_fv", {31'd0, fetch_valid}, 32'd0);
    drive(0, 0, 0, 0, 1);
    check("rs_tgt_fv", {31'd0, fetch_valid}, 32'd1);
    check("rs_tgt_pc", pc_next, 32'h204);
    check("rs_tgt_flush", {31'd0, flush}, 32'd0);

    drive(0, 1, 0, 0, 1);
    check("stall_pc", pc_next, 32'h204);
    check("stall_fv", {31'd0, fetch_valid}, 32'd0);
    check("cnt6", fetch_count, 32'd6);

    drive(0, 0, 1, 32'h40, 1);
    check("to40_pc", pc_next, 32'h40);
    drive(0, 0, 0, 0, 0);
    check("w40_fv", {31'd0, fetch_valid}, 32'd0);
    drive(0, 0, 1, 32'h80, 0);
    check("rw_flush", {31'd0, flush}, 32'd1);
    check("rw_fv", {31'd0, fetch_valid}, 32'd0);
    check("rw_pc", pc_next, 32'h80);
    drive(0, 0, 0, 0, 1);
    check("rw_tgt_fv", {31'd0, fetch_valid}, 32'd1);
    check("rw_tgt_pc", pc_next, 32'h84);

    drive(0, 0, 1, 32'hFFFF_FFFC, 1);
    check("cnt7", fetch_count, 32'd7);
    check("tomax_pc", pc_next, 32'hFFFF_FFFC);
    drive(0, 0, 0, 0, 1);
    check("wrap_pc", pc_next, 32'h0);
    check("wrap_fv", {31'd0, fetch_valid}, 32'd1);

    drive(0, 0, 0, 0, 1);
    force dut.fetch_count = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_count;
    check("pre_cwrap_fv", {31'd0, fetch_valid}, 32'd1);

    drive(0, 0, 1, 32'h102, 1);
    check("cnt_wrap", fetch_count, 32'd0);
    check("mis_flush", {31'd0, flush}, 32'd1);
`ifdef PC_TRAP_EN
    check("mis_pc", pc_next, 32'h4);
    check("mis_trap", {31'd0, trap}, 32'd1);
`else
    check("mis_pc", pc_next, 32'h100);
    check("mis_trap", {31'd0, trap}, 32'd0);
`endif
    drive(0, 0, 0, 0, 1);
    check("mis_cnt", fetch_count, 32'd0);
    check("mis_trap_off", {31'd0, trap}, 32'd0);
`ifdef PC_TRAP_EN
    check("mis_tgt_pc", pc_next, 32'h8);
`else
    check("mis_tgt_pc", pc_next, 32'h104);
`endif

    drive(0, 0, 0, 0, 0);
    check("pre_rst_fv", {31'd0, fetch_valid}, 32'd0);
    drive(1, 0, 0, 0, 0);
    check("mrst_pc", pc_next, 32'h0);
    check("mrst_fv", {31'd0, fetch_valid}, 32'd0);
    drive(0, 0, 0, 0, 1);
    check("mrst_boot_fv", {31'd0, fetch_valid}, 32'd0);
    check("mrst_cnt", fetch_count, 32'd0);
    drive(0, 0, 0, 0, 1);
    check("mrst_f0_fv", {31'd0, fetch_valid}, 32'd1);
    check("mrst_f0_pc", pc_next, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
